// File: rtl/sys_ctrl_unit_pkg.sv
// Shared definitions for the cpu32e2 system control unit: op encodings and
// the priority value that marks "no handler active".
package sysCtrlPkg;

  localparam int OP_WIDTH = 3;

  typedef enum logic [OP_WIDTH-1:0] {
    NO_OP         = 3'd0,
    SET_INTEN     = 3'd1,
    RESET_INTEN   = 3'd2,
    WRITE_FLAGS   = 3'd3,
    WRITE_SYSCALL = 3'd4,
    WRITE_DRL     = 3'd5,
    WRITE_IMR     = 3'd6,
    CLR_ERR       = 3'd7
  } sys_op_t;

  // Idle priority sits one above the lowest-priority channel so every
  // channel index compares as "more urgent" when no handler is running.
  function automatic int idle_pri(input int channels);
    return channels;
  endfunction

endpackage

// File: rtl/sys_ctrl_unit_prio.sv
// Combinational priority picker: lowest-index channel that is pending,
// unmasked and strictly more urgent than the running handler.
module sys_irq_prio #(
  parameter int CHANNELS = 8,
  parameter int PRI_W    = $clog2(CHANNELS + 1),
  parameter int IDX_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] pending,
  input  logic [CHANNELS-1:0] mask,
  input  logic [PRI_W-1:0]    pri_limit,
  output logic                valid,
  output logic [IDX_W-1:0]    index
);

  // Scan from the highest index down so the last hit is the most urgent channel.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i] && mask[i] && (PRI_W'(i) < pri_limit)) begin
        valid = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/sys_ctrl_unit.sv
// System-state unit: executes the per-cycle system op, owns flags/syscall/
// DRL/IMR and runs a nested, prioritised, edge-latched interrupt controller.
module sys_ctrl_unit
  import sysCtrlPkg::*;
#(
  parameter int IRQ_CHANNELS = 8,
  parameter int NEST_DEPTH   = 4,
  parameter int FLAG_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int IDX_W        = $clog2(IRQ_CHANNELS),
  parameter int NEST_W       = $clog2(NEST_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [OP_WIDTH-1:0]     op,
  input  logic [FLAG_WIDTH-1:0]   flagsIn,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic [IRQ_CHANNELS-1:0] irqReq,
  output logic [FLAG_WIDTH-1:0]   flags,
  output logic [DATA_WIDTH-1:0]   syscall,
  output logic [DATA_WIDTH-1:0]   drl,
  output logic [IRQ_CHANNELS-1:0] imr,
  output logic                    intEnable,
  output logic                    interruptPending,
  output logic [IDX_W-1:0]        irqVector,
  output logic [NEST_W-1:0]       nestLevel,
  output logic                    stackErr
);

  localparam int PRI_W = $clog2(IRQ_CHANNELS + 1);
  localparam logic [PRI_W-1:0] IDLE = PRI_W'(idle_pri(IRQ_CHANNELS));
  // Stack is sized to the full pointer range so the pointer indexes it
  // without truncation; slots at or above NEST_DEPTH are never written.
  localparam int SLOTS = 1 << NEST_W;

  sys_op_t                 cur_op;
  logic [IRQ_CHANNELS-1:0] irq_q;
  logic [IRQ_CHANNELS-1:0] pending;
  logic [IRQ_CHANNELS-1:0] pend_next;
  logic [PRI_W-1:0]        cur_pri;
  logic                    stack_ie  [SLOTS];
  logic [PRI_W-1:0]        stack_pri [SLOTS];
  logic                    win_valid;
  logic [IDX_W-1:0]        win_idx;
  logic                    stack_full;
  logic                    entry;

  assign cur_op     = sys_op_t'(op);
  assign stack_full = (nestLevel == NEST_W'(NEST_DEPTH));
  assign entry      = enable && (cur_op == RESET_INTEN);

  sys_irq_prio #(
    .CHANNELS (IRQ_CHANNELS),
    .PRI_W    (PRI_W),
    .IDX_W    (IDX_W)
  ) u_prio (
    .pending   (pending),
    .mask      (imr),
    .pri_limit (cur_pri),
    .valid     (win_valid),
    .index     (win_idx)
  );

  assign interruptPending = intEnable && win_valid;

  // Next pending: entry clears the accepted channel, then a fresh edge sets it again so it is never lost.
  always_comb begin
    pend_next = pending;
    if (entry && win_valid) begin
      pend_next[win_idx] = 1'b0;
    end
    pend_next = pend_next | (irqReq & ~irq_q);
  end

  // Edge capture every cycle; system ops only when the pipeline advances.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q     <= '0;
      pending   <= '0;
      flags     <= '0;
      syscall   <= '0;
      drl       <= '0;
      imr       <= '1;
      intEnable <= 1'b1;
      cur_pri   <= IDLE;
      irqVector <= '0;
      nestLevel <= '0;
      stackErr  <= 1'b0;
      for (int s = 0; s < SLOTS; s++) begin
        stack_ie[s]  <= 1'b0;
        stack_pri[s] <= '0;
      end
    end else begin
      irq_q   <= irqReq;
      pending <= pend_next;
      if (enable) begin
        case (cur_op)
          WRITE_FLAGS:   flags   <= flagsIn;
          WRITE_SYSCALL: syscall <= dataIn;
          WRITE_DRL:     drl     <= dataIn;
          WRITE_IMR:     imr     <= dataIn[IRQ_CHANNELS-1:0];
          RESET_INTEN: begin
            if (!stack_full) begin
              stack_ie[nestLevel]  <= intEnable;
              stack_pri[nestLevel] <= cur_pri;
              nestLevel            <= nestLevel + NEST_W'(1);
            end else begin
              stackErr <= 1'b1;
            end
            intEnable <= 1'b0;
            if (win_valid) begin
              cur_pri   <= PRI_W'(win_idx);
              irqVector <= win_idx;
            end
          end
          SET_INTEN: begin
            if (nestLevel != '0) begin
              intEnable <= stack_ie[nestLevel - NEST_W'(1)];
              cur_pri   <= stack_pri[nestLevel - NEST_W'(1)];
              nestLevel <= nestLevel - NEST_W'(1);
            end else begin
              intEnable <= 1'b1;
              cur_pri   <= IDLE;
              stackErr  <= 1'b1;
            end
          end
          CLR_ERR:       stackErr <= 1'b0;
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sys_ctrl_unit.sv
// Self-checking bench for sys_ctrl_unit: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the unit.
module tb_sys_ctrl_unit;
  import sysCtrlPkg::*;

  localparam int NCH   = 8;
  localparam int DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  op;
  logic [7:0]  flagsIn;
  logic [31:0] dataIn;
  logic [7:0]  irqReq;
  logic [7:0]  flags;
  logic [31:0] syscall;
  logic [31:0] drl;
  logic [7:0]  imr;
  logic        intEnable;
  logic        interruptPending;
  logic [2:0]  irqVector;
  logic [1:0]  nestLevel;
  logic        stackErr;

  int checks = 0;
  int errors = 0;

  sys_ctrl_unit #(
    .IRQ_CHANNELS (NCH),
    .NEST_DEPTH   (DEPTH),
    .FLAG_WIDTH   (8),
    .DATA_WIDTH   (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .op               (op),
    .flagsIn          (flagsIn),
    .dataIn           (dataIn),
    .irqReq           (irqReq),
    .flags            (flags),
    .syscall          (syscall),
    .drl              (drl),
    .imr              (imr),
    .intEnable        (intEnable),
    .interruptPending (interruptPending),
    .irqVector        (irqVector),
    .nestLevel        (nestLevel),
    .stackErr         (stackErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0]  m_flags, m_imr, m_pend, m_prev;
  logic [31:0] m_sys, m_drl;
  int          m_ie, m_cur, m_vec, m_err;
  int          m_stk_ie[$];
  int          m_stk_pri[$];

  function automatic int lowestEligible();
    for (int i = 0; i < NCH; i++)
      if (m_pend[i] && m_imr[i] && i < m_cur) return i;
    return -1;
  endfunction

  task automatic modelReset();
    m_flags = 0; m_sys = 0; m_drl = 0; m_imr = 8'hFF;
    m_pend = 0; m_prev = 0; m_ie = 1; m_cur = NCH; m_vec = 0; m_err = 0;
    m_stk_ie.delete(); m_stk_pri.delete();
  endtask

  task automatic modelStep(input logic en, input logic [2:0] o, input logic [31:0] d,
                           input logic [7:0] f, input logic [7:0] irq);
    logic [7:0] rise;
    int w;
    rise = irq & ~m_prev;
    w = lowestEligible();
    if (en) begin
      case (o)
        3'd3: m_flags = f;
        3'd4: m_sys = d;
        3'd5: m_drl = d;
        3'd6: m_imr = d[7:0];
        3'd2: begin
          if (m_stk_ie.size() < DEPTH) begin
            m_stk_ie.push_back(m_ie);
            m_stk_pri.push_back(m_cur);
          end else m_err = 1;
          m_ie = 0;
          if (w >= 0) begin
            m_pend[w] = 1'b0;
            m_cur = w;
            m_vec = w;
          end
        end
        3'd1: begin
          if (m_stk_ie.size() > 0) begin
            m_ie = m_stk_ie.pop_back();
            m_cur = m_stk_pri.pop_back();
          end else begin
            m_ie = 1; m_cur = NCH; m_err = 1;
          end
        end
        3'd7: m_err = 0;
        default: ;
      endcase
    end
    m_pend = m_pend | rise;
    m_prev = irq;
  endtask

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, ".flags"}, 32'(flags), 32'(m_flags));
    cmp({tag, ".syscall"}, syscall, m_sys);
    cmp({tag, ".drl"}, drl, m_drl);
    cmp({tag, ".imr"}, 32'(imr), 32'(m_imr));
    cmp({tag, ".intEnable"}, 32'(intEnable), 32'(m_ie));
    cmp({tag, ".interruptPending"}, 32'(interruptPending),
        32'((m_ie != 0) && (lowestEligible() >= 0)));
    cmp({tag, ".irqVector"}, 32'(irqVector), 32'(m_vec));
    cmp({tag, ".nestLevel"}, 32'(nestLevel), 32'(m_stk_ie.size()));
    cmp({tag, ".stackErr"}, 32'(stackErr), 32'(m_err));
    cmp({tag, ".pending"}, 32'(dut.pending), 32'(m_pend));
  endtask

  task automatic applyStimulus(input logic en, input logic [2:0] o, input logic [31:0] d,
                               input logic [7:0] f, input logic [7:0] irq, input string tag);
    enable = en; op = o; dataIn = d; flagsIn = f; irqReq = irq;
    @(posedge clk);
    modelStep(en, o, d, f, irq);
    #1;
    checkOutput(tag);
  endtask

  // Asserted mid-cycle so the outputs must clear before any clock edge.
  task automatic applyReset(input string tag);
    reset = 1'b1;
    #2;
    modelReset();
    checkOutput(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rirq;
    logic [2:0] rop;
    reset = 1'b0; enable = 1'b0; op = 3'd0; dataIn = '0; flagsIn = '0; irqReq = '0;
    @(posedge clk); #1;
    applyReset("reset0");
    cmp("reset.imr_const", 32'(imr), 32'hFF);
    cmp("reset.intEnable_const", 32'(intEnable), 32'd1);

    // Single pulse on channel 5, then interrupt entry
    applyStimulus(1, NO_OP, 0, 0, 8'h20, "pulse5");
    cmp("pulse5.intPending_const", 32'(interruptPending), 32'd1);
    applyStimulus(1, NO_OP, 0, 0, 8'h00, "pulse5_low");
    applyStimulus(1, RESET_INTEN, 0, 0, 8'h00, "entry5");
    cmp("entry5.vec_const", 32'(irqVector), 32'd5);

    // Nested requests 3 and 6 while in handler 5, then return
    applyStimulus(1, NO_OP, 0, 0, 8'h48, "pulse3_6");
    applyStimulus(1, WRITE_FLAGS, 32'hFFFF_FFFF, 8'hA5, 8'h00, "wflags");
    applyStimulus(1, SET_INTEN, $urandom, 0, 8'h00, "reti5");
    cmp("reti5.pending_const", 32'(dut.pending), 32'h48);
    applyStimulus(1, RESET_INTEN, 0, 0, 8'h00, "entry3");
    cmp("entry3.vec_const", 32'(irqVector), 32'd3);

    // Overflow: depth 2 already holds one entry, two more overflow once
    applyStimulus(1, RESET_INTEN, 0, 0, 8'h00, "entry_b");
    applyStimulus(1, RESET_INTEN, 0, 0, 8'h00, "entry_c");
    cmp("overflow.err_const", 32'(stackErr), 32'd1);
    applyStimulus(1, SET_INTEN, 0, 0, 8'h00, "pop1");
    applyStimulus(1, SET_INTEN, 0, 0, 8'h00, "pop2");
    applyStimulus(1, SET_INTEN, 0, 0, 8'h00, "pop3_underflow");
    applyStimulus(1, CLR_ERR, 0, 0, 8'h00, "clr_err");

    // Stall with a pending DRL write; an irq0 pulse inside the stall is kept
    applyStimulus(0, WRITE_DRL, 32'hDEADBEEF, 0, 8'h00, "stall1");
    applyStimulus(0, WRITE_DRL, 32'hDEADBEEF, 0, 8'h01, "stall2");
    applyStimulus(0, WRITE_DRL, 32'hDEADBEEF, 0, 8'h00, "stall3");
    applyStimulus(0, WRITE_DRL, 32'hDEADBEEF, 0, 8'h00, "stall4");
    cmp("stall.drl_const", drl, 32'h0);
    applyStimulus(1, WRITE_DRL, 32'hDEADBEEF, 0, 8'h00, "release");
    cmp("release.drl_const", drl, 32'hDEADBEEF);

    // New edge on channel 2 in the very cycle its entry is accepted
    applyReset("reset1");
    applyStimulus(1, NO_OP, 0, 0, 8'h04, "pulse2");
    applyStimulus(1, NO_OP, 0, 0, 8'h00, "pulse2_low");
    applyStimulus(1, RESET_INTEN, 0, 0, 8'h04, "entry2_rise");
    cmp("entry2.pending2_const", 32'(dut.pending[2]), 32'd1);

    // Randomized traffic including IMR writes and occasional async reset
    rirq = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) applyReset("rand_reset");
      rirq = rirq ^ 8'($urandom & $urandom & $urandom);
      rop = 3'($urandom);
      applyStimulus(($urandom_range(0, 7) != 0), rop, $urandom, 8'($urandom), rirq, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
